// File: rtl/tx_count_control.sv
// Transmit sequencer: streams count_w bytes from the result memory to the UART TX core.
// Optional inter-byte idle gap is compiled in when TX_GAP_EN is defined.
module tx_count_control #(
   parameter int DW         = 8,
   parameter int AW         = 4,
   parameter int GAP_CYCLES = 16
) (
   input  logic          CLOCK_50,
   input  logic          rst,
   input  logic          SW,
   input  logic [AW:0]   count_w,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          w_TX_DV,
   output logic [DW-1:0] w_TX_Byte,
   input  logic          w_TX_Active,
   input  logic          w_TX_Done,
   output logic          busy,
   output logic [AW:0]   count_r,
   output logic          done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_WAIT,
`ifdef TX_GAP_EN
      S_GAP,
`endif
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic          sw_prev_q;
   logic [AW:0]   len_q, len_d;
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] byte_q, byte_d;
   logic          dv_q, dv_d;
   logic          loaded_q, loaded_d;
   logic          start;
   logic [AW:0]   count_inc;
   logic          last_byte;

`ifdef TX_GAP_EN
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic          gap_end;
   assign gap_end = (gap_cnt_q == GW'(GAP_CYCLES - 1));
`endif

   if (GAP_CYCLES < 0) begin : g_gap_chk
      $error("GAP_CYCLES must be non-negative");
   end

   assign start     = SW & ~sw_prev_q;
   assign count_inc = count_q + 1'b1;
   assign last_byte = (count_inc == len_q);

   always_ff @(posedge CLOCK_50) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (count_w == '0) ? S_DONE : S_FETCH;
         S_FETCH: state_d = S_LOAD;
         S_LOAD:  if (!w_TX_Active) state_d = S_WAIT;
         S_WAIT: begin
            if (w_TX_Done) begin
               if (last_byte)             state_d = S_DONE;
`ifdef TX_GAP_EN
               else if (GAP_CYCLES == 0)  state_d = S_FETCH;
               else                       state_d = S_GAP;
`else
               else                       state_d = S_FETCH;
`endif
            end
         end
`ifdef TX_GAP_EN
         S_GAP:   if (gap_end) state_d = S_FETCH;
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The byte is captured on the first LOAD cycle only, so a stall cannot pick up later read data.
   always_comb begin
      len_d    = len_q;
      count_d  = count_q;
      addr_d   = addr_q;
      byte_d   = byte_q;
      dv_d     = 1'b0;
      loaded_d = loaded_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = count_w;
               count_d = '0;
               addr_d  = '0;
            end
         end
         S_FETCH: loaded_d = 1'b0;
         S_LOAD: begin
            if (!loaded_q) begin
               byte_d   = rd_data;
               loaded_d = 1'b1;
            end
            if (!w_TX_Active) dv_d = 1'b1;
         end
         S_WAIT: begin
            if (w_TX_Done) begin
               count_d = count_inc;
               if (!last_byte) addr_d = addr_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

`ifdef TX_GAP_EN
   always_comb begin
      gap_cnt_d = '0;
      if (state_q == S_GAP) gap_cnt_d = gap_cnt_q + 1'b1;
   end
`endif

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         sw_prev_q <= 1'b0;
         len_q     <= '0;
         count_q   <= '0;
         addr_q    <= '0;
         byte_q    <= '0;
         dv_q      <= 1'b0;
         loaded_q  <= 1'b0;
`ifdef TX_GAP_EN
         gap_cnt_q <= '0;
`endif
      end else begin
         sw_prev_q <= SW;
         len_q     <= len_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         byte_q    <= byte_d;
         dv_q      <= dv_d;
         loaded_q  <= loaded_d;
`ifdef TX_GAP_EN
         gap_cnt_q <= gap_cnt_d;
`endif
      end
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      rd_addr   = addr_q;
      w_TX_Byte = byte_q;
      w_TX_DV   = dv_q;
      count_r   = count_q;
   end

endmodule

// File: tb/tb_tx_count_control.sv
// Directed bench for tx_count_control with a registered-read memory and a TX core model
// that answers each DV with Done 10 cycles later.
module tb_tx_count_control;

   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int GAP = 4;
`ifdef TX_GAP_EN
   localparam int EXP_GAP = 3 + GAP;
`else
   localparam int EXP_GAP = 3;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sw = 1'b0;
   logic [AW:0]   count_w = '0;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data = '0;
   logic          tx_dv;
   logic [DW-1:0] tx_byte;
   logic          tx_active;
   logic          tx_done;
   logic          busy;
   logic [AW:0]   count_r;
   logic          done;

   logic          m_active = 1'b0;
   logic          m_done = 1'b0;
   int            tx_cnt = 0;
   logic          ovr_active = 1'b0;
   logic          ovr_done = 1'b0;

   logic [DW-1:0] mem [16];
   logic [DW-1:0] byte_log [$];
   int            gap_log [$];
   int            cyc = 0;
   int            done_edge = 0;
   logic          have_done = 1'b0;
   logic          dv_prev = 1'b0;
   int            dv_cnt = 0;
   int            done_cnt = 0;
   int            viol = 0;

   int            n_asserts = 0;
   int            n_fail = 0;

   assign tx_active = m_active | ovr_active;
   assign tx_done   = m_done | ovr_done;

   tx_count_control #(
      .DW(DW),
      .AW(AW),
      .GAP_CYCLES(GAP)
   ) dut (
      .CLOCK_50(clk),
      .rst(rst),
      .SW(sw),
      .count_w(count_w),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .w_TX_DV(tx_dv),
      .w_TX_Byte(tx_byte),
      .w_TX_Active(tx_active),
      .w_TX_Done(tx_done),
      .busy(busy),
      .count_r(count_r),
      .done(done)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr];

   // TX core model; deliberately ignores rst so an in-flight byte still reports Done
   always @(posedge clk) begin
      m_done <= 1'b0;
      if (tx_cnt != 0) begin
         tx_cnt <= tx_cnt - 1;
         if (tx_cnt == 1) begin
            m_done   <= 1'b1;
            m_active <= 1'b0;
         end
      end else if (tx_dv) begin
         m_active <= 1'b1;
         tx_cnt   <= 10;
      end
   end

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      dv_prev <= tx_dv;
      if (tx_dv) begin
         dv_cnt <= dv_cnt + 1;
         byte_log.push_back(tx_byte);
         if (dv_prev || tx_active) viol <= viol + 1;
         if (have_done) gap_log.push_back(cyc - done_edge);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (rst || done) have_done <= 1'b0;
      else if (tx_done && busy) begin
         have_done <= 1'b1;
         done_edge <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int max_cycles);
      int got = 0;
      for (int i = 0; i < max_cycles; i++) begin
         tick();
         if (done === 1'b1) begin
            got = 1;
            break;
         end
      end
      chk("done_within_bound", got, 1);
   endtask

   task automatic chk_frame(input string tag, input int b0, input int g0, input int nbytes);
      chk({tag, "_nbytes"}, byte_log.size() - b0, nbytes);
      for (int i = 0; i < nbytes && (b0 + i) < byte_log.size(); i++)
         chk({tag, "_byte"}, byte_log[b0 + i], mem[i]);
      chk({tag, "_ngaps"}, gap_log.size() - g0, nbytes - 1);
      for (int i = g0; i < gap_log.size(); i++)
         chk({tag, "_gap"}, gap_log[i], EXP_GAP);
   endtask

   initial begin
      int b0, g0, d0, v0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i * 7);
      mem[0] = 8'hA5;
      mem[1] = 8'h3C;
      mem[2] = 8'h7E;

      // Power-on reset
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_dv", tx_dv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count_r, 0);
      chk("rst_addr", rd_addr, 0);
      chk("rst_byte", tx_byte, 0);
      tick();

      // Three-byte frame with start-latency checks
      b0 = byte_log.size(); g0 = gap_log.size(); d0 = done_cnt;
      count_w = 5'd3;
      sw = 1'b1;
      tick();
      chk("f3_busy_k", busy, 1);
      chk("f3_dv_k", tx_dv, 0);
      tick();
      chk("f3_dv_k1", tx_dv, 0);
      tick();
      chk("f3_dv_k2", tx_dv, 1);
      chk("f3_byte0", tx_byte, 8'hA5);
      wait_done(300);
      chk("f3_busy_in_done", busy, 1);
      chk("f3_count", count_r, 3);
      chk("f3_addr", rd_addr, 2);
      tick();
      chk("f3_busy_after", busy, 0);
      chk("f3_done_after", done, 0);
      chk_frame("f3", b0, g0, 3);
      chk("f3_done_pulses", done_cnt - d0, 1);
      sw = 1'b0;

      // Spurious Done while idle
      ovr_done = 1'b1;
      tick();
      ovr_done = 1'b0;
      tick();
      chk("idle_done_count", count_r, 3);
      chk("idle_done_busy", busy, 0);

      // Zero-length frame
      v0 = dv_cnt;
      count_w = '0;
      sw = 1'b1;
      tick();
      chk("z_done", done, 1);
      chk("z_count", count_r, 0);
      tick();
      chk("z_done_off", done, 0);
      chk("z_busy_off", busy, 0);
      tick(); tick();
      chk("z_no_dv", dv_cnt - v0, 0);
      sw = 1'b0;
      tick();

      // Full depth
      b0 = byte_log.size(); g0 = gap_log.size(); d0 = done_cnt;
      count_w = 5'd16;
      sw = 1'b1;
      tick();
      sw = 1'b0;
      wait_done(1500);
      chk("full_count", count_r, 16);
      chk("full_addr", rd_addr, 15);
      tick();
      chk_frame("full", b0, g0, 16);
      chk("full_done_pulses", done_cnt - d0, 1);

      // Stall in LOAD, SW toggled mid-frame
      b0 = byte_log.size(); g0 = gap_log.size(); d0 = done_cnt;
      ovr_active = 1'b1;
      count_w = 5'd2;
      sw = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_dv_low", tx_dv, 0);
         if (i == 1) sw = 1'b0;
         if (i == 3) sw = 1'b1;
      end
      ovr_active = 1'b0;
      tick();
      chk("stall_dv_release", tx_dv, 1);
      chk("stall_byte", tx_byte, 8'hA5);
      wait_done(300);
      chk("stall_count", count_r, 2);
      for (int i = 0; i < 4; i++) tick();
      chk("stall_no_restart", busy, 0);
      chk_frame("stall", b0, g0, 2);
      chk("stall_done_pulses", done_cnt - d0, 1);
      sw = 1'b0;
      tick();

      // Reset mid-WAIT with count_r = 2
      v0 = dv_cnt;
      count_w = 5'd4;
      sw = 1'b1;
      tick();
      sw = 1'b0;
      begin
         int got = 0;
         for (int i = 0; i < 300; i++) begin
            tick();
            if (dv_cnt - v0 == 2 && tx_dv === 1'b1) begin
               got = 1;
               break;
            end
         end
         chk("rw_third_dv_seen", got, 1);
      end
      chk("rw_count_pre", count_r, 2);
      rst = 1'b1;
      tick(); tick();
      chk("rw_dv", tx_dv, 0);
      chk("rw_busy", busy, 0);
      chk("rw_done", done, 0);
      chk("rw_count", count_r, 0);
      chk("rw_addr", rd_addr, 0);
      chk("rw_byte", tx_byte, 0);
      rst = 1'b0;
      v0 = dv_cnt;
      for (int i = 0; i < 20; i++) tick();
      chk("rw_late_done_count", count_r, 0);
      chk("rw_late_busy", busy, 0);
      chk("rw_late_no_dv", dv_cnt - v0, 0);

      chk("dv_protocol_viol", viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_count_control.md
# tx_count_control

Transmit-side sequencer for the UART link. After the receive path has filled the result memory, it reads `count_w` bytes back out in address order, hands each byte to the UART transmitter with a one-cycle data-valid strobe, and waits for the transmitter's done pulse before advancing. It sits between the result memory read port and the UART TX core, under the same `SW` operator control as the receive side.

## Interface
- `DW`, 8: byte width.
- `AW`, 4: result memory address width; memory depth is 2^AW.
- `GAP_CYCLES`, 16: idle cycles between bytes; used only when `TX_GAP_EN` is defined.

- `CLOCK_50`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `SW`  in  1: start switch; a rising edge starts a frame.
- `count_w`  in  AW+1: number of bytes to send, 0..2^AW; sampled at frame start.
- `rd_addr`  out  AW: result memory read address.
- `rd_data`  in  DW: result memory read data, valid one cycle after `rd_addr`.
- `w_TX_DV`  out  1: one-cycle strobe to the UART TX core.
- `w_TX_Byte`  out  DW: byte to transmit; stable from `w_TX_DV` until `w_TX_Done`.
- `w_TX_Active`  in  1: TX core is busy.
- `w_TX_Done`  in  1: one-cycle pulse when a byte has left the line.
- `busy`  out  1: high from frame start until the `done` cycle, inclusive.
- `count_r`  out  AW+1: bytes completed in the current or last frame.
- `done`  out  1: one-cycle pulse at frame end.

## Operation
- Edge detect: `SW` is registered into `sw_d`. Start is `SW & ~sw_d`, and it is evaluated in IDLE only. A start edge seen in any other state is ignored. `sw_d` also resets to 0.
- Frame start latches `count_w` into `len`, clears `count_r` and `rd_addr` to 0, and sets `busy`.
- States:
  - IDLE: waits for start. If start arrives with `len == 0`, go to DONE. Otherwise go to FETCH.
  - FETCH: `rd_addr` is presented; go to LOAD.
  - LOAD: `rd_data` is latched into `w_TX_Byte`. If `w_TX_Active` is low, pulse `w_TX_DV` and go to WAIT. If it is high, stay in LOAD and re-latch nothing.
  - WAIT: on `w_TX_Done`, increment `count_r`. If the new `count_r` equals `len`, go to DONE. Otherwise increment `rd_addr` and go to GAP (macro defined) or FETCH (macro undefined).
  - GAP: counts `GAP_CYCLES`, then goes to FETCH.
  - DONE: pulses `done` for one cycle, clears `busy`, returns to IDLE.
- Width rules:
  - `count_r` is AW+1 bits wide, so `len = 2^AW` completes without wrap.
  - `rd_addr` wraps modulo 2^AW but is never incremented past the last byte.
- `w_TX_Done` outside WAIT is ignored.
- Inputs `count_w` and `rd_data` are not observed outside their sampling cycles.
- Reset in any state, including mid-byte:
  - Next cycle is IDLE.
  - `w_TX_DV`, `busy`, `done` = 0.
  - `count_r`, `rd_addr`, `w_TX_Byte` = 0.
  - A byte already in flight in the TX core is abandoned, not counted.

## Timing
- Reset values: every output is 0.
- Start edge sampled at edge k: FETCH at k+1, LOAD at k+2, `w_TX_DV` high during cycle k+3 (TX core idle).
- `w_TX_DV` is high for exactly one cycle per byte and never while `w_TX_Active` is high.
- `w_TX_Done` sampled at edge t:
  - Macro undefined: next `w_TX_DV` at t+3.
  - Macro defined: next `w_TX_DV` at t+3+`GAP_CYCLES`.
- Last `w_TX_Done` at edge t: `done` high in cycle t+1, `busy` low from t+2.
- `len == 0`: `done` follows the start edge by one cycle; no `w_TX_DV`.

## Configuration
- `TX_GAP_EN` defined: GAP state and a gap counter of width clog2(`GAP_CYCLES`+1) are compiled in. `GAP_CYCLES` idle cycles are inserted after each non-final byte.
- `TX_GAP_EN` undefined: GAP state and counter are absent; WAIT goes directly to FETCH and `GAP_CYCLES` is ignored.

## Test plan
- Reset: hold `rst` 2 cycles mid-WAIT with `count_r = 2` -> all outputs 0 and IDLE the next cycle; a later `w_TX_Done` has no effect.
- Three-byte frame: memory 0xA5, 0x3C, 0x7E; `count_w = 3`; TX model with Done 10 cycles after DV -> three DV pulses carrying 0xA5, 0x3C, 0x7E in order, `count_r` = 3, one `done` pulse, `busy` then falls.
- Zero length: `count_w = 0`, `SW` rises -> no `w_TX_DV`, `done` one cycle after the start edge, `count_r` = 0.
- Full depth with `AW = 4`: `count_w = 16` -> 16 bytes at addresses 0..15, `count_r` = 16, `rd_addr` ends at 15.
- Stall and spurious inputs: hold `w_TX_Active` high for 5 cycles in LOAD -> DV delayed until Active falls. Toggle `SW` mid-frame -> no restart. Pulse `w_TX_Done` in IDLE -> `count_r` unchanged.
- Gap: `TX_GAP_EN` defined, `GAP_CYCLES = 4` -> exactly 7 cycles from each non-final Done to the next DV; with the macro undefined -> 3 cycles.
